// File: rtl/rv_bus_pkg.sv
// rv_bus_pkg
//   Shared types and constants for the core's data-bus slave (dmem_responder
//   and its dmem_bank word store).
//   Contents:
//     dmem_state_t     responder FSM states (IDLE, WAIT)
//     BYTES_PER_WORD   byte lanes in a default-width (32-bit) bus word
//     WAIT_CNT_W       width of the wait-state counter
//     WAIT_STATES_MAX  largest wait-state count the counter can express
//     bytes_per_word() byte lanes for an arbitrary bus width
package rv_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dmem_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
    localparam int WAIT_CNT_W         = 4;
    localparam int WAIT_STATES_MAX    = 15;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank
//   Word-organised data RAM behind dmem_responder. Synchronous write with
//   per-lane write enables, registered read port. All byte-enable handling
//   lives here; the responder above only decides when an access happens.
//   Optional feature macro: DMEM_BYTE_EN_EN (adds the byteenable input; when
//   undefined every write replaces the whole word).
//   Ports:
//     clk         rising-edge clock
//     reset       synchronous active-low; clears rdata only, memory retained
//     we          write strobe (one accepted write)
//     re          read strobe (one accepted read)
//     word_addr   word index
//     wdata       store data
//     byteenable  lane mask for writes (DMEM_BYTE_EN_EN only)
//     rdata       registered read data, holds between reads
module dmem_bank
    import rv_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic                    re,
    input  logic [ADDR_WIDTH-3:0]   word_addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [DATA_WIDTH/8-1:0] byteenable,
`endif
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB    = bytes_per_word(DATA_WIDTH);
    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [NB-1:0]         lane_we;

    always_comb begin
        lane_we = '0;
        if (we) begin
`ifdef DMEM_BYTE_EN_EN
            lane_we = byteenable;
`else
            lane_we = '1;
`endif
        end
    end

    // Memory contents are deliberately not reset so data survives a core reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (lane_we[b]) begin
                mem[word_addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[word_addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Slave end of the RV32IM core's data bus. Commands are held by the master
//   until waitrequest drops; each command is stretched by WAIT_STATES wait
//   cycles, after which a write updates the RAM and a read returns registered
//   data qualified by a one-cycle readdatavalid pulse.
//   Optional feature macro: DMEM_BYTE_EN_EN (byteenable port, lane writes).
//   Ports:
//     clk            rising-edge clock
//     reset          synchronous active-low
//     address        byte address, bits [1:0] ignored
//     read, write    commands, held until accepted (write wins if both)
//     writedata      store data
//     byteenable     write lane mask (DMEM_BYTE_EN_EN only)
//     waitrequest    high = command not accepted this cycle
//     readdata       read result, holds its last value
//     readdatavalid  one-cycle pulse qualifying readdata
module dmem_responder
    import rv_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [DATA_WIDTH/8-1:0] byteenable,
`endif
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid
);

    localparam bit HAS_WAIT = (WAIT_STATES != 0);
    // First WAIT cycle already counts as one wait state, hence the -1.
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        HAS_WAIT ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    dmem_state_t           state, state_nxt;
    logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
    logic                  cmd;
    logic                  accept;
    logic                  bank_we;
    logic                  bank_re;
    logic                  vld_p1;

    assign cmd = read | write;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (cmd && HAS_WAIT) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    cnt_nxt = '0;
                end
            end
            WAIT: begin
                // A dropped command aborts the pending access outright.
                if (!cmd) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        waitrequest = 1'b1;
        accept      = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (cmd && HAS_WAIT) begin
                        waitrequest = 1'b1;
                    end else begin
                        waitrequest = 1'b0;
                        accept      = cmd;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        waitrequest = 1'b0;
                        accept      = cmd;
                    end
                end
                default: begin
                    waitrequest = 1'b1;
                end
            endcase
        end
    end

    // Write has priority: a simultaneous read is silently dropped.
    assign bank_we = accept & write;
    assign bank_re = accept & read & ~write;

    // Accept edge -> readdatavalid stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bank_re;
        end
    end

    assign readdatavalid = vld_p1;

    dmem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .we         (bank_we),
        .re         (bank_re),
        .word_addr  (address[ADDR_WIDTH-1:2]),
        .wdata      (writedata),
`ifdef DMEM_BYTE_EN_EN
        .byteenable (byteenable),
`endif
        .rdata      (readdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    // Instance A: WAIT_STATES = 2
    logic [9:0]  address;
    logic        read, write;
    logic [31:0] writedata;
    logic        waitrequest, readdatavalid;
    logic [31:0] readdata;

    // Instance B: WAIT_STATES = 0
    logic [9:0]  b_address;
    logic        b_read, b_write;
    logic [31:0] b_writedata;
    logic        b_waitrequest, b_readdatavalid;
    logic [31:0] b_readdata;

`ifdef DMEM_BYTE_EN_EN
    logic [3:0]  byteenable;
    logic [3:0]  b_byteenable;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(2)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
`ifdef DMEM_BYTE_EN_EN
        .byteenable    (byteenable),
`endif
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .address       (b_address),
        .read          (b_read),
        .write         (b_write),
        .writedata     (b_writedata),
`ifdef DMEM_BYTE_EN_EN
        .byteenable    (b_byteenable),
`endif
        .waitrequest   (b_waitrequest),
        .readdata      (b_readdata),
        .readdatavalid (b_readdatavalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one command on instance A for WAIT_STATES+1 cycles and check
    // the waitrequest pattern; cycle 0 also checks the previous read pulse.
    task automatic access(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [31:0] d, input logic prev_rv,
                          input logic [31:0] prev_rd, input string tag);
        for (int i = 0; i <= 2; i++) begin
            read = rd; write = wr; address = a; writedata = d;
            #1;
            chk({tag, "_wreq"}, {31'd0, waitrequest}, {31'd0, (i < 2)});
            if (i == 0) begin
                chk({tag, "_prev_rvalid"}, {31'd0, readdatavalid}, {31'd0, prev_rv});
                if (prev_rv) chk({tag, "_prev_rdata"}, readdata, prev_rd);
            end else begin
                chk({tag, "_rvalid_busy"}, {31'd0, readdatavalid}, 32'd0);
            end
            next_cycle();
        end
    endtask

    // One idle cycle on instance A, checking the read pulse of the last access.
    task automatic settle(input logic exp_rv, input logic [31:0] exp_rd, input string tag);
        read = 1'b0; write = 1'b0;
        #1;
        chk({tag, "_rvalid"}, {31'd0, readdatavalid}, {31'd0, exp_rv});
        if (exp_rv) chk({tag, "_rdata"}, readdata, exp_rd);
        next_cycle();
    endtask

    initial begin
        reset = 1'b0;
        read = 0; write = 0; address = '0; writedata = '0;
        b_read = 0; b_write = 0; b_address = '0; b_writedata = '0;
`ifdef DMEM_BYTE_EN_EN
        byteenable = 4'hF; b_byteenable = 4'hF;
`endif
        next_cycle();
        next_cycle();
        chk("rst_wreq", {31'd0, waitrequest}, 32'd1);
        chk("rst_rvalid", {31'd0, readdatavalid}, 32'd0);
        chk("rst_rdata", readdata, 32'd0);
        chk("rst_b_wreq", {31'd0, b_waitrequest}, 32'd1);
        reset = 1'b1;

        // Basic write then read with two wait states
        access(1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 1'b0, 32'd0, "wr010");
        settle(1'b0, 32'd0, "wr010");
        access(1'b1, 1'b0, 10'h010, 32'd0, 1'b0, 32'd0, "rd010");
        settle(1'b1, 32'hDEADBEEF, "rd010");
        settle(1'b0, 32'd0, "rd010_after");
        chk("rdata_hold", readdata, 32'hDEADBEEF);

        // Read dropped in the first WAIT cycle
        read = 1'b1; address = 10'h020;
        #1;
        chk("abort_wreq0", {31'd0, waitrequest}, 32'd1);
        next_cycle();
        read = 1'b0;
        #1;
        chk("abort_rvalid1", {31'd0, readdatavalid}, 32'd0);
        next_cycle();
        chk("abort_rvalid2", {31'd0, readdatavalid}, 32'd0);
        next_cycle();
        chk("abort_rvalid3", {31'd0, readdatavalid}, 32'd0);
        access(1'b1, 1'b0, 10'h010, 32'd0, 1'b0, 32'd0, "post_abort");
        settle(1'b1, 32'hDEADBEEF, "post_abort");

        // read and write together: write performed, no read pulse
        access(1'b1, 1'b1, 10'h030, 32'hA5A5A5A5, 1'b0, 32'd0, "rw030");
        settle(1'b0, 32'd0, "rw030");
        access(1'b1, 1'b0, 10'h030, 32'd0, 1'b0, 32'd0, "rd030");
        settle(1'b1, 32'hA5A5A5A5, "rd030");

        // Back-to-back reads: second wait phase overlaps first pulse
        access(1'b1, 1'b0, 10'h010, 32'd0, 1'b0, 32'd0, "b2b_a");
        access(1'b1, 1'b0, 10'h030, 32'd0, 1'b1, 32'hDEADBEEF, "b2b_b");
        settle(1'b1, 32'hA5A5A5A5, "b2b_b");

        // Top word, then address change during WAIT (accept-cycle address used)
        access(1'b0, 1'b1, 10'h3FC, 32'hCAFEF00D, 1'b0, 32'd0, "wr3fc");
        settle(1'b0, 32'd0, "wr3fc");
        for (int i = 0; i <= 2; i++) begin
            read = 1'b1; address = (i < 2) ? 10'h010 : 10'h3FF;
            #1;
            chk("achg_wreq", {31'd0, waitrequest}, {31'd0, (i < 2)});
            next_cycle();
        end
        settle(1'b1, 32'hCAFEF00D, "achg");

        // Read in the cycle right after a write to the same word
        access(1'b0, 1'b1, 10'h040, 32'h13572468, 1'b0, 32'd0, "wr040");
        access(1'b1, 1'b0, 10'h040, 32'd0, 1'b0, 32'd0, "rd040");
        settle(1'b1, 32'h13572468, "rd040");

        // Reset pulsed mid-WAIT aborts a write to 0x010
        write = 1'b1; address = 10'h010; writedata = 32'h0BADF00D;
        #1;
        chk("rstw_wreq0", {31'd0, waitrequest}, 32'd1);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("rstw_wreq1", {31'd0, waitrequest}, 32'd1);
        next_cycle();
        write = 1'b0;
        #1;
        chk("rstw_wreq2", {31'd0, waitrequest}, 32'd1);
        chk("rstw_rvalid", {31'd0, readdatavalid}, 32'd0);
        chk("rstw_rdata", readdata, 32'd0);
        next_cycle();
        reset = 1'b1;
        access(1'b1, 1'b0, 10'h010, 32'd0, 1'b0, 32'd0, "post_rst");
        settle(1'b1, 32'hDEADBEEF, "post_rst");

`ifdef DMEM_BYTE_EN_EN
        // Lane writes
        byteenable = 4'hF;
        access(1'b0, 1'b1, 10'h050, 32'h11223344, 1'b0, 32'd0, "be_full");
        byteenable = 4'b0101;
        access(1'b0, 1'b1, 10'h050, 32'hAABBCCDD, 1'b0, 32'd0, "be_0101");
        byteenable = 4'b0000;
        access(1'b0, 1'b1, 10'h050, 32'hFFFFFFFF, 1'b0, 32'd0, "be_none");
        byteenable = 4'hF;
        access(1'b1, 1'b0, 10'h050, 32'd0, 1'b0, 32'd0, "be_rd");
        settle(1'b1, 32'h11BB33DD, "be_rd");
`endif

        // Zero wait states: write then read the next cycle
        b_write = 1'b1; b_address = 10'h004; b_writedata = 32'h12345678;
        #1;
        chk("b_wr_wreq", {31'd0, b_waitrequest}, 32'd0);
        next_cycle();
        b_write = 1'b0; b_read = 1'b1;
        #1;
        chk("b_rd_wreq", {31'd0, b_waitrequest}, 32'd0);
        chk("b_rd_rvalid0", {31'd0, b_readdatavalid}, 32'd0);
        next_cycle();
        b_read = 1'b0;
        #1;
        chk("b_rvalid1", {31'd0, b_readdatavalid}, 32'd1);
        chk("b_rdata", b_readdata, 32'h12345678);
        next_cycle();
        chk("b_rvalid2", {31'd0, b_readdatavalid}, 32'd0);
        chk("b_rdata_hold", b_readdata, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-mapped data-memory responder for the RV32IM core's load/store port: the slave end of the CPU's data bus. It accepts read/write commands through a waitrequest/readdatavalid handshake, inserts a configurable number of wait states, and returns registered read data. It replaces the zero-latency single-cycle data memory once the core is given stall support, and sits between the core's data port and the on-chip RAM.

## Interface
- DATA_WIDTH, 32, bus word width; must be a multiple of 8.
- ADDR_WIDTH, 10, byte-address width; depth is 2^(ADDR_WIDTH-2) words.
- WAIT_STATES, 2, wait cycles before a command is accepted; legal range 0..15.
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clk.
- address  input  ADDR_WIDTH  byte address; bits [1:0] ignored, word index = address[ADDR_WIDTH-1:2].
- read  input  1  read command; held by the master until accepted.
- write  input  1  write command; held by the master until accepted.
- writedata  input  DATA_WIDTH  store data; held with write.
- byteenable  input  DATA_WIDTH/8  byte lanes to write; present only with DMEM_BYTE_EN_EN.
- waitrequest  output  1  high = command not accepted this cycle.
- readdata  output  DATA_WIDTH  read result; valid only when readdatavalid is high.
- readdatavalid  output  1  one-cycle pulse qualifying readdata.

## Operation
- States: IDLE, WAIT. 4-bit wait counter cnt.
- IDLE, no command: waitrequest=0, stay in IDLE.
- IDLE, command, WAIT_STATES=0: accept in the same cycle (waitrequest=0), stay in IDLE.
- IDLE, command, WAIT_STATES>0: waitrequest=1, cnt<=WAIT_STATES-1, go to WAIT.
- WAIT, cnt!=0: waitrequest=1, cnt decrements.
- WAIT, cnt==0: waitrequest=0, accept, return to IDLE.
- Accepted write: the memory word updates at the accept edge.
- Accepted read: readdata is registered at the accept edge. readdatavalid=1 for exactly the following cycle.
- Command dropped during WAIT (read=write=0): abort. Return to IDLE, cnt<=0, no access, no readdatavalid.
- read and write both high: the write is performed and the read is discarded, so no readdatavalid.
- Address or command changing during WAIT: the values sampled in the accept cycle are used.
- Read in the cycle after a write to the same word returns the new data.
- Address aliasing: bits above ADDR_WIDTH do not exist, so accesses wrap modulo the depth.
- readdata holds its last value when readdatavalid=0.

## Timing
- Command first asserted in cycle 0: accepted in cycle WAIT_STATES; readdatavalid in cycle WAIT_STATES+1.
- Back-to-back: a new command may be presented in the cycle after acceptance. Its wait phase overlaps the previous readdatavalid.
- Throughput: one access per WAIT_STATES+1 cycles.
- While reset=0: state=IDLE, cnt=0, readdatavalid=0, readdata=0, waitrequest=1. Memory contents are retained.
- Reset asserted during WAIT aborts the pending access. The first command after reset is released sees the full WAIT_STATES.

## Configuration
- DMEM_BYTE_EN_EN defined:
  - byteenable port exists.
  - An accepted write updates only the lanes whose bit is 1.
  - byteenable=0 performs no update but still completes the handshake.
- DMEM_BYTE_EN_EN undefined:
  - No byteenable port.
  - Every accepted write replaces the full word.
- Reads always return the full word in both builds.

## Structure
- Package rv_bus_pkg:
  - dmem_state_t enum {IDLE, WAIT}.
  - BYTES_PER_WORD = DATA_WIDTH/8.
  - WAIT_CNT_W = 4.
  - WAIT_STATES_MAX = 15.
- Sub-module dmem_bank: word array with synchronous write, per-lane write enables, and registered read port. The byte-enable path is confined to this sub-module.
- The top level holds the FSM, counter, handshake and readdatavalid register.

## Test plan
- Write 0xDEADBEEF to 0x010 with WAIT_STATES=2 -> waitrequest high for cycles 0-1, low in cycle 2; a later read of 0x010 gives readdata=0xDEADBEEF with readdatavalid only in cycle 3.
- WAIT_STATES=0, write 0x12345678 to 0x004, then read 0x004 in the next cycle -> waitrequest never high; readdatavalid one cycle after the read with 0x12345678.
- Read of 0x020 started, read dropped in cycle 1 of WAIT -> no readdatavalid; the FSM is back in IDLE and the next command again waits 2 cycles.
- read=write=1 to 0x030 with writedata 0xA5A5A5A5 -> the word becomes 0xA5A5A5A5, no readdatavalid.
- DMEM_BYTE_EN_EN: word 0x11223344, write 0xAABBCCDD with byteenable=4'b0101 -> read returns 0x11BB33DD.
- reset=0 pulsed mid-WAIT -> readdatavalid=0, readdata=0, the write is not performed, and pre-reset memory contents are still readable afterwards.
